// File: rtl/ex_mc_if.sv
// Execute-stage bus: issue side (ID/EX) in, result side (EX/MEM) and stall out.
// master = upstream pipeline driving the op, slave = execute stage.
interface ex_mc_if #(parameter int DATA_W = 32);
  logic              valid_i;
  logic              flush_i;
  logic [7:0]        aluop_i;
  logic [2:0]        alusel_i;
  logic [DATA_W-1:0] reg1_i;
  logic [DATA_W-1:0] reg2_i;
  logic [4:0]        wd_i;
  logic              wreg_i;
  logic              valid_o;
  logic [4:0]        wd_o;
  logic              wreg_o;
  logic [DATA_W-1:0] wdata_o;
  logic [DATA_W-1:0] rem_o;
  logic              stallreq_o;

  modport master (
    output valid_i, flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  valid_o, wd_o, wreg_o, wdata_o, rem_o, stallreq_o
  );

  modport slave (
    input  valid_i, flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output valid_o, wd_o, wreg_o, wdata_o, rem_o, stallreq_o
  );
endinterface

// File: rtl/ex_mc.sv
// Registered execute stage: single-cycle logic/shift ops plus an iterative
// restoring signed/unsigned divider that stalls the pipeline while it runs.
// Optional feature macro: EX_MC_ROTATE_EN adds ROL/ROR in the shift class.
module ex_mc #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic    clk,
  input  logic    rst,
  ex_mc_if.slave  bus
);
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOT  = 8'b0010_1000;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;
`ifdef EX_MC_ROTATE_EN
  localparam logic [7:0] OP_ROL  = 8'b0000_1000;
  localparam logic [7:0] OP_ROR  = 8'b0000_1001;
`endif

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0]  a, b;
  logic [SHAMT_W-1:0] amt;
  logic               is_div, ready, div_go, div_zero, single_go, last_step;

  // divider state: quo shifts the dividend out as quotient bits shift in
  logic [DATA_W-1:0]  quo, rem_r, dvs;
  logic [SHAMT_W-1:0] count;
  logic               neg_q, neg_r, wreg_l;
  logic [4:0]         wd_l;

  assign a      = bus.reg1_i;
  assign b      = bus.reg2_i;
  assign amt    = b[SHAMT_W-1:0];
  assign is_div = (bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU);
  // DONE accepts a new op: its result lands one cycle after the divide's
  assign ready  = (state != DIV);

  assign div_go    = ready && bus.valid_i && !bus.flush_i && is_div && (b != '0);
  assign div_zero  = ready && bus.valid_i && !bus.flush_i && is_div && (b == '0);
  assign single_go = ready && bus.valid_i && !bus.flush_i && !is_div;
  assign last_step = (state == DIV) && (count == SHAMT_W'(DATA_W-1));

  assign bus.stallreq_o = (ready && bus.valid_i && is_div && (b != '0)) || (state == DIV);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state; flush overrides everything
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = div_go ? DIV : IDLE;
      DIV:        if (last_step) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (bus.flush_i) state_nxt = IDLE;
  end

  // single-cycle result; unknown class/op yields zero
  logic [DATA_W-1:0] res;
`ifdef EX_MC_ROTATE_EN
  logic [2*DATA_W-1:0] rot_l, rot_r;
`endif
  always_comb begin
    res = '0;
`ifdef EX_MC_ROTATE_EN
    rot_l = {a, a} << amt;
    rot_r = {a, a} >> amt;
`endif
    case (bus.alusel_i)
      RES_LOGIC: case (bus.aluop_i)
        OP_OR:   res = a | b;
        OP_AND:  res = a & b;
        OP_XOR:  res = a ^ b;
        OP_NOT:  res = ~a;
        default: res = '0;
      endcase
      RES_SHIFT: case (bus.aluop_i)
        OP_SLL:  res = a << amt;
        OP_SRL:  res = a >> amt;
        OP_SRA:  res = $unsigned($signed(a) >>> amt);
`ifdef EX_MC_ROTATE_EN
        OP_ROL:  res = rot_l[2*DATA_W-1:DATA_W];
        OP_ROR:  res = rot_r[DATA_W-1:0];
`endif
        default: res = '0;
      endcase
      default: res = '0;
    endcase
  end

  // one restoring step: shift next dividend bit into the partial remainder
  logic [DATA_W:0]   shifted, diff;
  logic              ge;
  logic [DATA_W-1:0] rem_nxt, quo_nxt, q_fin, r_fin;
  always_comb begin
    shifted = {rem_r, quo[DATA_W-1]};
    diff    = shifted - {1'b0, dvs};
    ge      = !diff[DATA_W];
    rem_nxt = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_nxt = {quo[DATA_W-2:0], ge};
    q_fin   = neg_q ? -quo_nxt : quo_nxt;
    r_fin   = neg_r ? -rem_nxt : rem_nxt;
  end

  // divider datapath: latch magnitudes and signs on issue, step while in DIV
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo <= '0; rem_r <= '0; dvs <= '0; count <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; wd_l <= '0; wreg_l <= 1'b0;
    end else if (div_go) begin
      neg_q  <= (bus.aluop_i == OP_DIV) && (a[DATA_W-1] ^ b[DATA_W-1]);
      neg_r  <= (bus.aluop_i == OP_DIV) && a[DATA_W-1];
      quo    <= ((bus.aluop_i == OP_DIV) && a[DATA_W-1]) ? -a : a;
      dvs    <= ((bus.aluop_i == OP_DIV) && b[DATA_W-1]) ? -b : b;
      rem_r  <= '0;
      count  <= '0;
      wd_l   <= bus.wd_i;
      wreg_l <= bus.wreg_i;
    end else if (state == DIV) begin
      quo   <= quo_nxt;
      rem_r <= rem_nxt;
      count <= count + 1'b1;
    end
  end

  // output register: divide result on the step into DONE, else single-cycle/div-by-zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_o <= 1'b0; bus.wreg_o <= 1'b0; bus.wd_o <= '0;
      bus.wdata_o <= '0;   bus.rem_o  <= '0;
    end else begin
      bus.valid_o <= 1'b0;
      bus.wreg_o  <= 1'b0;
      if (bus.flush_i) begin
        bus.valid_o <= 1'b0;
      end else if (last_step) begin
        bus.valid_o <= 1'b1;
        bus.wreg_o  <= wreg_l;
        bus.wd_o    <= wd_l;
        bus.wdata_o <= q_fin;
        bus.rem_o   <= r_fin;
      end else if (single_go) begin
        bus.valid_o <= 1'b1;
        bus.wreg_o  <= bus.wreg_i;
        bus.wd_o    <= bus.wd_i;
        bus.wdata_o <= res;
        bus.rem_o   <= '0;
      end else if (div_zero) begin
        bus.valid_o <= 1'b1;
        bus.wreg_o  <= bus.wreg_i;
        bus.wd_o    <= bus.wd_i;
        bus.wdata_o <= '1;
        bus.rem_o   <= a;
      end
    end
  end
endmodule

// File: tb/tb_ex_mc.sv
// Directed bench for ex_mc: table of single-cycle vectors plus hand-written
// divide, divide-by-zero, flush and reset sequences.
module tb_ex_mc;
  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOT  = 8'b0010_1000;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;
  localparam logic [7:0] OP_ROL  = 8'b0000_1000;
  localparam logic [7:0] OP_ROR  = 8'b0000_1001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_mc_if #(.DATA_W(32)) bus();
  ex_mc #(.DATA_W(32), .SHAMT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic issue(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wr);
    bus.valid_i = 1'b1; bus.aluop_i = op; bus.alusel_i = sel;
    bus.reg1_i = a; bus.reg2_i = b; bus.wd_i = wd; bus.wreg_i = wr;
  endtask

  // issue a divide at the next negedge, count stall cycles, check the result,
  // then issue an OR in the DONE cycle and check it lands next cycle
  task automatic run_div(input string nm, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expq, input logic [31:0] expr);
    int cyc;
    @(negedge clk);
    issue(op, RES_NOP, a, b, 5'd9, 1'b1);
    #1 chk({nm, " stall_at_issue"}, {31'b0, bus.stallreq_o}, 32'd1);
    cyc = 1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    #1;
    while (bus.stallreq_o && cyc < 100) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk({nm, " stall_cycles"}, cyc, 32'd33);
    chk({nm, " valid"}, {31'b0, bus.valid_o}, 32'd1);
    chk({nm, " quot"}, bus.wdata_o, expq);
    chk({nm, " rem"}, bus.rem_o, expr);
    chk({nm, " wd/wreg"}, {26'b0, bus.wd_o, bus.wreg_o}, {26'b0, 5'd9, 1'b1});
    issue(OP_OR, RES_LOGIC, 32'h0000_00F0, 32'h0000_000F, 5'd3, 1'b1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    #1;
    chk({nm, " or_after_done valid"}, {31'b0, bus.valid_o}, 32'd1);
    chk({nm, " or_after_done data"}, bus.wdata_o, 32'h0000_00FF);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int nv;
    int vcnt;
    bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.aluop_i = '0; bus.alusel_i = '0;
    bus.reg1_i = '0; bus.reg2_i = '0; bus.wd_i = '0; bus.wreg_i = 1'b0;

    vecs[0]  = '{OP_OR,  RES_LOGIC, 32'h0F0F_0000, 32'h0000_F0F0, 32'h0F0F_F0F0};
    vecs[1]  = '{OP_AND, RES_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00};
    vecs[2]  = '{OP_XOR, RES_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
    vecs[3]  = '{OP_NOT, RES_LOGIC, 32'h1234_5678, 32'h0000_0000, 32'hEDCB_A987};
    vecs[4]  = '{OP_SLL, RES_SHIFT, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
    vecs[5]  = '{OP_SRL, RES_SHIFT, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
    vecs[6]  = '{OP_SRA, RES_SHIFT, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
    vecs[7]  = '{OP_SRA, RES_SHIFT, 32'h8000_0000, 32'h0000_0025, 32'hFC00_0000};
    vecs[8]  = '{OP_SRA, RES_SHIFT, 32'h7000_000F, 32'h0000_0000, 32'h7000_000F};
    vecs[9]  = '{8'hFF,  RES_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{OP_OR,  3'b111,    32'h1234_0000, 32'h0000_5678, 32'h0000_0000};
`ifdef EX_MC_ROTATE_EN
    vecs[11] = '{OP_ROL, RES_SHIFT, 32'h8000_0001, 32'h0000_0004, 32'h0000_0018};
    vecs[12] = '{OP_ROR, RES_SHIFT, 32'h8000_0001, 32'h0000_0004, 32'h1800_0000};
`else
    vecs[11] = '{OP_ROL, RES_SHIFT, 32'h8000_0001, 32'h0000_0004, 32'h0000_0000};
    vecs[12] = '{OP_ROR, RES_SHIFT, 32'h8000_0001, 32'h0000_0004, 32'h0000_0000};
`endif
    nv = 13;

    // reset state
    #12;
    chk("reset valid", {31'b0, bus.valid_o}, 32'd0);
    chk("reset wdata", bus.wdata_o, 32'd0);
    chk("reset rem", bus.rem_o, 32'd0);
    chk("reset wd/wreg", {26'b0, bus.wd_o, bus.wreg_o}, 32'd0);
    chk("reset stall", {31'b0, bus.stallreq_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single-cycle table, back to back
    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, 5'(i + 1), 1'(i % 2));
      #1 chk($sformatf("vec%0d stall", i), {31'b0, bus.stallreq_o}, 32'd0);
      @(negedge clk);
      bus.valid_i = 1'b0;
      #1;
      chk($sformatf("vec%0d wdata", i), bus.wdata_o, vecs[i].exp);
      chk($sformatf("vec%0d valid", i), {31'b0, bus.valid_o}, 32'd1);
      chk($sformatf("vec%0d rem", i), bus.rem_o, 32'd0);
      chk($sformatf("vec%0d wd/wreg", i), {26'b0, bus.wd_o, bus.wreg_o},
          {26'b0, 5'(i + 1), 1'(i % 2)});
    end
    @(negedge clk);
    #1 chk("valid pulse drops", {30'b0, bus.valid_o, bus.wreg_o}, 32'd0);

    // divides
    run_div("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_div("divu big", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15);

    // divide by zero: no stall, immediate result
    @(negedge clk);
    issue(OP_DIVU, RES_NOP, 32'd100, 32'd0, 5'd4, 1'b1);
    #1 chk("div0 stall", {31'b0, bus.stallreq_o}, 32'd0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    #1;
    chk("div0 valid", {31'b0, bus.valid_o}, 32'd1);
    chk("div0 quot", bus.wdata_o, 32'hFFFF_FFFF);
    chk("div0 rem", bus.rem_o, 32'd100);
    chk("div0 stall after", {31'b0, bus.stallreq_o}, 32'd0);

    // flush at DIV cycle 10, then a follow-up OR
    @(negedge clk);
    issue(OP_DIVU, RES_NOP, 32'd100, 32'd7, 5'd5, 1'b1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (9) @(negedge clk);
    #1 chk("flush pre stall", {31'b0, bus.stallreq_o}, 32'd1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    chk("flush stall", {31'b0, bus.stallreq_o}, 32'd0);
    chk("flush valid", {31'b0, bus.valid_o}, 32'd0);
    issue(OP_OR, RES_LOGIC, 32'h0F0F_0000, 32'h0000_F0F0, 5'd6, 1'b1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    #1;
    chk("post-flush or valid", {31'b0, bus.valid_o}, 32'd1);
    chk("post-flush or data", bus.wdata_o, 32'h0F0F_F0F0);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o) vcnt++;
    end
    chk("flushed div never valid", vcnt, 32'd0);

    // flush together with issue: op discarded
    @(negedge clk);
    issue(OP_OR, RES_LOGIC, 32'h1, 32'h2, 5'd7, 1'b1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    #1 chk("flush+issue valid", {30'b0, bus.valid_o, bus.wreg_o}, 32'd0);

    // reset in DIV cycle 5
    @(negedge clk);
    issue(OP_DIV, RES_NOP, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid-div reset wdata", bus.wdata_o, 32'd0);
    chk("mid-div reset rem/valid", {bus.rem_o[30:0], bus.valid_o}, 32'd0);
    chk("mid-div reset stall", {31'b0, bus.stallreq_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(OP_XOR, RES_LOGIC, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 5'd2, 1'b1);
    #1 chk("after reset stall", {31'b0, bus.stallreq_o}, 32'd0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    #1 chk("after reset xor", bus.wdata_o, 32'h0F0F_0F0F);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1);
  end
endmodule
